// File: rtl/multicyc_mcu_hs_pkg.sv
// Shared definitions for the multicycle MIPS main control unit.
//   Opcodes     : instr[31:26] encodings understood by the controller.
//   ALUops      : ALU operation encodings driven on aluop.
//   MultcycCtrl : FSM state type, datapath select encodings, trap causes
//                 and small decode helpers.
package Opcodes;
  localparam logic [5:0] OP_RR     = 6'b000000;
  localparam logic [5:0] OP_BGELTZ = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
endpackage

package ALUops;
  localparam logic [3:0] ALUop_ADD  = 4'd0;
  localparam logic [3:0] ALUop_ADDU = 4'd1;
  localparam logic [3:0] ALUop_SUB  = 4'd2;
  localparam logic [3:0] ALUop_SUBU = 4'd3;
  localparam logic [3:0] ALUop_AND  = 4'd4;
  localparam logic [3:0] ALUop_OR   = 4'd5;
  localparam logic [3:0] ALUop_XOR  = 4'd6;
  localparam logic [3:0] ALUop_NOR  = 4'd7;
  localparam logic [3:0] ALUop_SLT  = 4'd8;
  localparam logic [3:0] ALUop_SLTU = 4'd9;
  // ALU decodes the funct field itself for R-type instructions.
  localparam logic [3:0] ALUop_RR   = 4'd15;
endpackage

package MultcycCtrl;
  import Opcodes::*;
  import ALUops::*;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADDR, S_MEMRD, S_MEMWR, S_MEMWRBCK,
    S_RREXEC, S_RRWRBCK, S_RIEXEC, S_RIWRBCK,
    S_BRANCH, S_JMP, S_LUI, S_TRAP
  } state_t;

  // mem_addr_sel
  localparam logic       ADDR_PC      = 1'b0;
  localparam logic       ADDR_ALUOUT  = 1'b1;
  // alu_srca_sel
  localparam logic       SRCA_PC      = 1'b0;
  localparam logic       SRCA_RS      = 1'b1;
  // alu_srcb_sel
  localparam logic [2:0] SRCB_RT      = 3'd0;
  localparam logic [2:0] SRCB_FOUR    = 3'd1;
  localparam logic [2:0] SRCB_IMM     = 3'd2;
  localparam logic [2:0] SRCB_BEQIMM  = 3'd3;
  localparam logic [2:0] SRCB_ZERO    = 3'd4;
  // wreg_dst_sel
  localparam logic       DST_RT       = 1'b0;
  localparam logic       DST_RD       = 1'b1;
  // wreg_data_sel
  localparam logic [1:0] WB_ALUOUT    = 2'd0;
  localparam logic [1:0] WB_MEMDATA   = 2'd1;
  localparam logic [1:0] WB_LUI       = 2'd2;
  // nxt_pc_sel
  localparam logic [1:0] PC_PLUS4     = 2'd0;
  localparam logic [1:0] PC_BRANCH    = 2'd1;
  localparam logic [1:0] PC_JMP       = 2'd2;
  // trap_cause
  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  // States that issue a memory request and therefore wait on mem_ack.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

  // ALU operation for the register-immediate ALU group.
  function automatic logic [3:0] ri_aluop(input logic [5:0] op);
    case (op)
      OP_ADDI:  return ALUop_ADD;
      OP_ADDIU: return ALUop_ADDU;
      OP_SLTI:  return ALUop_SLT;
      OP_SLTIU: return ALUop_SLTU;
      OP_ANDI:  return ALUop_AND;
      OP_ORI:   return ALUop_OR;
      OP_XORI:  return ALUop_XOR;
      default:  return ALUop_ADD;
    endcase
  endfunction
endpackage

// File: rtl/multicyc_mcu_hs_watchdog.sv
// mem_wait_watchdog: counts cycles a memory request waits for its ack.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart the count (asserted when entering a memory state)
//   req, ack   : current request / acknowledge
//   timeout    : this is wait cycle number WAIT_MAX with no ack
// An ack in the limit cycle masks timeout, so a late-but-legal ack wins.
module mem_wait_watchdog #(
  parameter int WAIT_MAX = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic req,
  input  logic ack,
  output logic timeout
);
  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (req && !ack) begin
      count <= count + 1'b1;
    end
  end

  // count holds the number of earlier wait cycles, so the current cycle is
  // wait number count+1.
  assign timeout = req && !ack && (count == LIMIT);
endmodule

// File: rtl/multicyc_mcu_hs.sv
// multicyc_mcu_hs: main control unit for the multicycle MIPS datapath with
// a variable-latency memory handshake.
//   clk, reset        : clock, synchronous active-high reset
//   opcode            : instr[31:26] from the IR
//   mem_ack           : memory completes the current access this cycle
//   mem_req           : memory request, held until mem_ack
//   datapath controls : mem_addr_sel, ir_we, alu_srca_sel, mem_we, reg_we,
//                       pc_we, wreg_dst_sel, alu_srcb_sel, aluop,
//                       wreg_data_sel, nxt_pc_sel
//   branch qualifiers : is_beq, is_bne, is_bgeltz, is_blez, is_bgtz, is_jmp
//   retire            : pulse in the last cycle of each instruction
//   trap, trap_cause  : halted and why (1 illegal opcode, 2 memory timeout)
//   cycle_cnt         : free-running cycle counter
//   retire_cnt        : retired-instruction counter
// The cycle right after a reset edge is quiet (every output 0, state Fetch),
// so an access interrupted by reset is dropped before a new fetch starts.
module multicyc_mcu_hs
  import Opcodes::*, ALUops::*, MultcycCtrl::*;
#(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             alu_srca_sel,
  output logic             mem_we,
  output logic             reg_we,
  output logic             pc_we,
  output logic             wreg_dst_sel,
  output logic [2:0]       alu_srcb_sel,
  output logic [3:0]       aluop,
  output logic [1:0]       wreg_data_sel,
  output logic [1:0]       nxt_pc_sel,
  output logic             is_beq,
  output logic             is_bne,
  output logic             is_bgeltz,
  output logic             is_blez,
  output logic             is_bgtz,
  output logic             is_jmp,
  output logic             retire,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);
  state_t             state_reg, state_next;
  logic               hold_reg;
  logic [1:0]         cause_reg, cause_next;
  logic [CNT_W-1:0]   cycle_reg, retire_reg;
  logic               wd_req, wd_clear, wd_timeout;

  // Request seen by the watchdog comes straight from the state register,
  // keeping it free of the combinational next-state logic below.
  assign wd_req   = !hold_reg && is_mem_state(state_reg);
  assign wd_clear = is_mem_state(state_next) && (state_next != state_reg);

  mem_wait_watchdog #(.WAIT_MAX(WAIT_MAX)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .req     (wd_req),
    .ack     (mem_ack),
    .timeout (wd_timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_FETCH;
      hold_reg   <= 1'b1;
      cause_reg  <= CAUSE_NONE;
      cycle_reg  <= '0;
      retire_reg <= '0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= 1'b0;
      cause_reg <= cause_next;
      cycle_reg <= cycle_reg + 1'b1;
      if (retire) begin
        retire_reg <= retire_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    cause_next    = cause_reg;
    mem_req       = 1'b0;
    mem_addr_sel  = ADDR_PC;
    ir_we         = 1'b0;
    alu_srca_sel  = SRCA_PC;
    mem_we        = 1'b0;
    reg_we        = 1'b0;
    pc_we         = 1'b0;
    wreg_dst_sel  = DST_RT;
    alu_srcb_sel  = SRCB_RT;
    aluop         = ALUop_ADD;
    wreg_data_sel = WB_ALUOUT;
    nxt_pc_sel    = PC_PLUS4;
    is_beq        = 1'b0;
    is_bne        = 1'b0;
    is_bgeltz     = 1'b0;
    is_blez       = 1'b0;
    is_bgtz       = 1'b0;
    is_jmp        = 1'b0;
    retire        = 1'b0;

    if (!hold_reg) begin
      unique case (state_reg)
        S_FETCH: begin
          mem_req      = 1'b1;
          mem_addr_sel = ADDR_PC;
          alu_srca_sel = SRCA_PC;
          alu_srcb_sel = SRCB_FOUR;
          aluop        = ALUop_ADD;
          nxt_pc_sel   = PC_PLUS4;
          if (mem_ack) begin
            ir_we      = 1'b1;
            pc_we      = 1'b1;
            state_next = S_DECODE;
          end else if (wd_timeout) begin
            state_next = S_TRAP;
            cause_next = CAUSE_TIMEOUT;
          end
        end
        S_DECODE: begin
          alu_srca_sel = SRCA_PC;
          alu_srcb_sel = SRCB_BEQIMM;
          aluop        = ALUop_ADD;
          case (opcode)
            OP_LW, OP_SW:                  state_next = S_MEMADDR;
            OP_RR:                         state_next = S_RREXEC;
            OP_BGELTZ, OP_BEQ, OP_BNE,
            OP_BLEZ, OP_BGTZ:              state_next = S_BRANCH;
            OP_J:                          state_next = S_JMP;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI:      state_next = S_RIEXEC;
            OP_LUI:                        state_next = S_LUI;
            default: begin
              state_next = S_TRAP;
              cause_next = CAUSE_ILLEGAL;
            end
          endcase
        end
        S_MEMADDR: begin
          alu_srca_sel = SRCA_RS;
          alu_srcb_sel = SRCB_IMM;
          aluop        = ALUop_ADD;
          state_next   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_req      = 1'b1;
          mem_addr_sel = ADDR_ALUOUT;
          if (mem_ack) begin
            state_next = S_MEMWRBCK;
          end else if (wd_timeout) begin
            state_next = S_TRAP;
            cause_next = CAUSE_TIMEOUT;
          end
        end
        S_MEMWR: begin
          mem_req      = 1'b1;
          mem_addr_sel = ADDR_ALUOUT;
          mem_we       = 1'b1;
          if (mem_ack) begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end else if (wd_timeout) begin
            state_next = S_TRAP;
            cause_next = CAUSE_TIMEOUT;
          end
        end
        S_MEMWRBCK: begin
          reg_we        = 1'b1;
          wreg_dst_sel  = DST_RT;
          wreg_data_sel = WB_MEMDATA;
          retire        = 1'b1;
          state_next    = S_FETCH;
        end
        S_RREXEC: begin
          alu_srca_sel = SRCA_RS;
          alu_srcb_sel = SRCB_RT;
          aluop        = ALUop_RR;
          state_next   = S_RRWRBCK;
        end
        S_RRWRBCK: begin
          reg_we        = 1'b1;
          wreg_dst_sel  = DST_RD;
          wreg_data_sel = WB_ALUOUT;
          retire        = 1'b1;
          state_next    = S_FETCH;
        end
        S_RIEXEC: begin
          alu_srca_sel = SRCA_RS;
          alu_srcb_sel = SRCB_IMM;
          aluop        = ri_aluop(opcode);
          state_next   = S_RIWRBCK;
        end
        S_RIWRBCK: begin
          reg_we        = 1'b1;
          wreg_dst_sel  = DST_RT;
          wreg_data_sel = WB_ALUOUT;
          retire        = 1'b1;
          state_next    = S_FETCH;
        end
        S_BRANCH: begin
          alu_srca_sel = SRCA_RS;
          aluop        = ALUop_SUB;
          nxt_pc_sel   = PC_BRANCH;
          // Two-register compares use Rt; the sign tests compare against 0.
          alu_srcb_sel = (opcode == OP_BEQ || opcode == OP_BNE) ? SRCB_RT : SRCB_ZERO;
          is_beq       = (opcode == OP_BEQ);
          is_bne       = (opcode == OP_BNE);
          is_bgeltz    = (opcode == OP_BGELTZ);
          is_blez      = (opcode == OP_BLEZ);
          is_bgtz      = (opcode == OP_BGTZ);
          retire       = 1'b1;
          state_next   = S_FETCH;
        end
        S_JMP: begin
          nxt_pc_sel = PC_JMP;
          pc_we      = 1'b1;
          is_jmp     = 1'b1;
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        S_LUI: begin
          reg_we        = 1'b1;
          wreg_dst_sel  = DST_RT;
          wreg_data_sel = WB_LUI;
          retire        = 1'b1;
          state_next    = S_FETCH;
        end
        S_TRAP: begin
          state_next = S_TRAP;
        end
        default: begin
          state_next = S_FETCH;
        end
      endcase
    end
  end

  assign trap       = (state_reg == S_TRAP);
  assign trap_cause = cause_reg;
  assign cycle_cnt  = cycle_reg;
  assign retire_cnt = retire_reg;
endmodule

// File: tb/tb_multicyc_mcu_hs.sv
// Self-checking bench for multicyc_mcu_hs. Each instruction is turned into a
// per-cycle list of (opcode, mem_ack, expected controls) pushed to a queue;
// the queue is then drained one clock per entry and the DUT compared.
module tb_multicyc_mcu_hs;
  import ALUops::*;
  import MultcycCtrl::*;

  localparam int CNT_W    = 32;
  localparam int WAIT_MAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic [5:0]       opcode = 6'd0;
  logic             mem_ack = 1'b0;
  logic             mem_req, mem_addr_sel, ir_we, alu_srca_sel, mem_we, reg_we, pc_we, wreg_dst_sel;
  logic [2:0]       alu_srcb_sel;
  logic [3:0]       aluop;
  logic [1:0]       wreg_data_sel, nxt_pc_sel, trap_cause;
  logic             is_beq, is_bne, is_bgeltz, is_blez, is_bgtz, is_jmp, retire, trap;
  logic [CNT_W-1:0] cycle_cnt, retire_cnt;

  multicyc_mcu_hs #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .alu_srca_sel(alu_srca_sel), .mem_we(mem_we), .reg_we(reg_we),
    .pc_we(pc_we), .wreg_dst_sel(wreg_dst_sel), .alu_srcb_sel(alu_srcb_sel),
    .aluop(aluop), .wreg_data_sel(wreg_data_sel), .nxt_pc_sel(nxt_pc_sel),
    .is_beq(is_beq), .is_bne(is_bne), .is_bgeltz(is_bgeltz), .is_blez(is_blez),
    .is_bgtz(is_bgtz), .is_jmp(is_jmp), .retire(retire), .trap(trap),
    .trap_cause(trap_cause), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  typedef struct packed {
    logic       mem_req, mem_addr_sel, ir_we, alu_srca_sel, mem_we, reg_we, pc_we, wreg_dst_sel;
    logic [2:0] srcb;
    logic [3:0] aluop;
    logic [1:0] wdata, npc;
    logic [5:0] q;     // {beq, bne, bgeltz, blez, bgtz, jmp}
    logic       retire, trap;
    logic [1:0] cause;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic       ack;
    ctl_t       exp;
  } step_t;

  typedef enum int {K_LW, K_SW, K_RR, K_RI, K_BR, K_J, K_LUI, K_ILL} kind_t;

  step_t            sb[$];
  int               checks = 0;
  int               errors = 0;
  int               step_no = 0;
  logic [CNT_W-1:0] exp_cyc = '0;
  logic [CNT_W-1:0] exp_ret = '0;

  function automatic ctl_t sample();
    ctl_t c;
    c.mem_req = mem_req;  c.mem_addr_sel = mem_addr_sel; c.ir_we = ir_we;
    c.alu_srca_sel = alu_srca_sel; c.mem_we = mem_we; c.reg_we = reg_we;
    c.pc_we = pc_we;      c.wreg_dst_sel = wreg_dst_sel; c.srcb = alu_srcb_sel;
    c.aluop = aluop;      c.wdata = wreg_data_sel; c.npc = nxt_pc_sel;
    c.q = {is_beq, is_bne, is_bgeltz, is_blez, is_bgtz, is_jmp};
    c.retire = retire;    c.trap = trap; c.cause = trap_cause;
    return c;
  endfunction

  function automatic void push(input logic [5:0] op, input logic ack, input ctl_t c);
    step_t s;
    s.op = op; s.ack = ack; s.exp = c;
    sb.push_back(s);
  endfunction

  // Fetch with fw wait cycles; ack arrives in request cycle fw+1.
  function automatic void add_fetch(input logic [5:0] op, input int fw, input logic give_ack);
    ctl_t c = '0;
    c.mem_req = 1'b1; c.mem_addr_sel = ADDR_PC; c.alu_srca_sel = SRCA_PC;
    c.srcb = SRCB_FOUR; c.aluop = ALUop_ADD; c.npc = PC_PLUS4;
    for (int i = 0; i < fw; i++) push(op, 1'b0, c);
    if (give_ack) begin
      c.ir_we = 1'b1; c.pc_we = 1'b1;
      push(op, 1'b1, c);
    end
  endfunction

  function automatic void add_decode(input logic [5:0] op);
    ctl_t c = '0;
    c.alu_srca_sel = SRCA_PC; c.srcb = SRCB_BEQIMM; c.aluop = ALUop_ADD;
    push(op, 1'b1, c);   // stray ack while not requesting must be ignored
  endfunction

  function automatic void add_memaddr(input logic [5:0] op);
    ctl_t c = '0;
    c.alu_srca_sel = SRCA_RS; c.srcb = SRCB_IMM; c.aluop = ALUop_ADD;
    push(op, 1'b0, c);
  endfunction

  function automatic void add_trap(input logic [5:0] op, input logic [1:0] cause, input int n);
    ctl_t c = '0;
    c.trap = 1'b1; c.cause = cause;
    for (int i = 0; i < n; i++) push(op, logic'(i % 2), c);
  endfunction

  function automatic void add_instr(input logic [5:0] op, input kind_t k, input int fw,
                                    input int mw, input logic [3:0] alu, input logic [5:0] qb);
    ctl_t c = '0;
    add_fetch(op, fw, 1'b1);
    add_decode(op);
    case (k)
      K_LW: begin
        add_memaddr(op);
        c.mem_req = 1'b1; c.mem_addr_sel = ADDR_ALUOUT;
        for (int i = 0; i < mw; i++) push(op, 1'b0, c);
        push(op, 1'b1, c);
        c = '0; c.reg_we = 1'b1; c.wreg_dst_sel = DST_RT; c.wdata = WB_MEMDATA; c.retire = 1'b1;
        push(op, 1'b0, c);
      end
      K_SW: begin
        add_memaddr(op);
        c.mem_req = 1'b1; c.mem_addr_sel = ADDR_ALUOUT; c.mem_we = 1'b1;
        for (int i = 0; i < mw; i++) push(op, 1'b0, c);
        c.retire = 1'b1;
        push(op, 1'b1, c);
      end
      K_RR: begin
        c.alu_srca_sel = SRCA_RS; c.srcb = SRCB_RT; c.aluop = ALUop_RR;
        push(op, 1'b0, c);
        c = '0; c.reg_we = 1'b1; c.wreg_dst_sel = DST_RD; c.wdata = WB_ALUOUT; c.retire = 1'b1;
        push(op, 1'b0, c);
      end
      K_RI: begin
        c.alu_srca_sel = SRCA_RS; c.srcb = SRCB_IMM; c.aluop = alu;
        push(op, 1'b0, c);
        c = '0; c.reg_we = 1'b1; c.wreg_dst_sel = DST_RT; c.wdata = WB_ALUOUT; c.retire = 1'b1;
        push(op, 1'b0, c);
      end
      K_BR: begin
        c.alu_srca_sel = SRCA_RS; c.aluop = ALUop_SUB; c.npc = PC_BRANCH;
        c.srcb = (qb[5] || qb[4]) ? SRCB_RT : SRCB_ZERO;
        c.q = qb; c.retire = 1'b1;
        push(op, 1'b0, c);
      end
      K_J: begin
        c.npc = PC_JMP; c.pc_we = 1'b1; c.q = 6'b000001; c.retire = 1'b1;
        push(op, 1'b0, c);
      end
      K_LUI: begin
        c.reg_we = 1'b1; c.wreg_dst_sel = DST_RT; c.wdata = WB_LUI; c.retire = 1'b1;
        push(op, 1'b0, c);
      end
      default: add_trap(op, 2'd1, 3);
    endcase
  endfunction

  // Drain the scoreboard: one clock per entry, inputs at negedge, check #1 later.
  task automatic run_sb();
    step_t s;
    ctl_t  act;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk);
      opcode  = s.op;
      mem_ack = s.ack;
      #1;
      act = sample();
      checks++;
      assert (act === s.exp) else begin
        errors++;
        $error("FAIL ctl step=%0d op=%b observed=%h expected=%h", step_no, s.op, act, s.exp);
      end
      checks++;
      assert (cycle_cnt === exp_cyc) else begin
        errors++;
        $error("FAIL cycle_cnt step=%0d observed=%0d expected=%0d", step_no, cycle_cnt, exp_cyc);
      end
      checks++;
      assert (retire_cnt === exp_ret) else begin
        errors++;
        $error("FAIL retire_cnt step=%0d observed=%0d expected=%0d", step_no, retire_cnt, exp_ret);
      end
      $display("step %0d op=%b ack=%b ctl=%h retire_cnt=%0d", step_no, s.op, s.ack, act, retire_cnt);
      step_no++;
      exp_cyc = exp_cyc + 1'b1;
      if (s.exp.retire) exp_ret = exp_ret + 1'b1;
    end
  endtask

  // One reset cycle, then check the quiet post-reset cycle.
  task automatic do_reset();
    ctl_t act;
    @(negedge clk);
    reset   = 1'b1;
    mem_ack = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    act = sample();
    checks++;
    assert (act === ctl_t'('0)) else begin
      errors++;
      $error("FAIL reset_ctl observed=%h expected=0 (mem_req=%b mem_we=%b)", act, mem_req, mem_we);
    end
    checks++;
    assert ({cycle_cnt, retire_cnt} === '0) else begin
      errors++;
      $error("FAIL reset_cnt observed=%0d/%0d expected=0/0", cycle_cnt, retire_cnt);
    end
    $display("reset: ctl=%h cycle_cnt=%0d retire_cnt=%0d", act, cycle_cnt, retire_cnt);
    exp_cyc = 1;
    exp_ret = '0;
  endtask

  initial begin
    ctl_t c;
    do_reset();

    // ADDI, zero-wait memory: retire in cycle 4, retire_cnt then 1.
    add_instr(6'b001000, K_RI, 0, 0, ALUop_ADD, 6'd0);
    // LW with 3-cycle ack delay in both Fetch and MemRd: 11 cycles.
    add_instr(6'b100011, K_LW, 3, 3, 4'd0, 6'd0);
    // SLTIU and the rest of the immediate group.
    add_instr(6'b001011, K_RI, 0, 0, ALUop_SLTU, 6'd0);
    add_instr(6'b001010, K_RI, 1, 0, ALUop_SLT, 6'd0);
    add_instr(6'b001001, K_RI, 0, 0, ALUop_ADDU, 6'd0);
    add_instr(6'b001100, K_RI, 0, 0, ALUop_AND, 6'd0);
    add_instr(6'b001101, K_RI, 0, 0, ALUop_OR, 6'd0);
    add_instr(6'b001110, K_RI, 0, 0, ALUop_XOR, 6'd0);
    add_instr(6'b101011, K_SW, 0, 0, 4'd0, 6'd0);
    add_instr(6'b101011, K_SW, 3, 3, 4'd0, 6'd0);
    add_instr(6'b100011, K_LW, 0, 0, 4'd0, 6'd0);
    add_instr(6'b000000, K_RR, 0, 0, 4'd0, 6'd0);
    add_instr(6'b000100, K_BR, 0, 0, 4'd0, 6'b100000);
    add_instr(6'b000101, K_BR, 0, 0, 4'd0, 6'b010000);
    add_instr(6'b000001, K_BR, 0, 0, 4'd0, 6'b001000);
    add_instr(6'b000110, K_BR, 0, 0, 4'd0, 6'b000100);
    add_instr(6'b000111, K_BR, 0, 0, 4'd0, 6'b000010);
    // Ack on the WAIT_MAX-th request cycle wins over the watchdog.
    add_instr(6'b000010, K_J, WAIT_MAX - 1, 0, 4'd0, 6'd0);
    add_instr(6'b001111, K_LUI, 0, 0, 4'd0, 6'd0);
    // Illegal opcode: Trap right after Decode, cause 1, cycles keep counting.
    add_instr(6'b111111, K_ILL, 0, 0, 4'd0, 6'd0);
    run_sb();
    do_reset();

    add_instr(6'b100000, K_ILL, 0, 0, 4'd0, 6'd0);
    run_sb();
    do_reset();

    // Fetch never acked: Trap after WAIT_MAX wait cycles, cause 2.
    add_fetch(6'b001000, WAIT_MAX, 1'b0);
    add_trap(6'b001000, 2'd2, 3);
    run_sb();
    do_reset();

    // Reset in the middle of a MemWr wait.
    add_fetch(6'b101011, 0, 1'b1);
    add_decode(6'b101011);
    add_memaddr(6'b101011);
    c = '0;
    c.mem_req = 1'b1; c.mem_addr_sel = ADDR_ALUOUT; c.mem_we = 1'b1;
    push(6'b101011, 1'b0, c);
    push(6'b101011, 1'b0, c);
    run_sb();
    do_reset();

    // Normal operation resumes after the reset.
    add_instr(6'b001000, K_RI, 0, 0, ALUop_ADD, 6'd0);
    run_sb();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
